// File: rtl/cpu_mem_responder.sv
// Word-addressed memory model that answers CPU read/write requests a fixed number
// of cycles after capture; a side preload port writes full words in any state.
module cpu_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        mem_err,
    input  logic        init_we,
    input  logic [31:0] init_addr,
    input  logic [31:0] init_data
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY < 4) ? 1 : $clog2(LATENCY - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_LOAD = (LATENCY > 2) ? CW'(LATENCY - 2) : CNT_ZERO;
    localparam logic [29:0]   DEPTH_W  = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [29:0]   cap_addr_q, cap_addr_d;
    logic [31:0]   cap_wdata_q, cap_wdata_d;
    logic [3:0]    cap_be_q, cap_be_d;
    logic          cap_rd_q, cap_rd_d;
    logic          cap_wr_q, cap_wr_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          resp_q, resp_d;
    logic          err_q, err_d;

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic [29:0]   eff_addr_s;
    logic [31:0]   eff_wdata_s;
    logic [3:0]    eff_be_s;
    logic          eff_rd_s, eff_wr_s;
    logic          enter_resp_s;
    logic          in_range_s;
    logic          init_ok_s;
    logic          cpu_we_s;
    logic [AW-1:0] cpu_idx_s, init_idx_s;
    logic [31:0]   base_word_s, cpu_word_s;
    logic          addr_lsb_unused_s;

    assign addr_lsb_unused_s = ^{mem_address[1:0], init_addr[1:0]};

    // With LATENCY=1 the RESP edge is the capture edge, so the access uses live inputs.
    always_comb begin
        if (state_q == S_IDLE) begin
            eff_addr_s  = mem_address[31:2];
            eff_wdata_s = mem_wdata;
            eff_be_s    = mem_byte_enable;
            eff_rd_s    = mem_read;
            eff_wr_s    = mem_write;
        end else begin
            eff_addr_s  = cap_addr_q;
            eff_wdata_s = cap_wdata_q;
            eff_be_s    = cap_be_q;
            eff_rd_s    = cap_rd_q;
            eff_wr_s    = cap_wr_q;
        end
    end

    // Next-state, latency counter and request capture.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cap_addr_d   = cap_addr_q;
        cap_wdata_d  = cap_wdata_q;
        cap_be_d     = cap_be_q;
        cap_rd_d     = cap_rd_q;
        cap_wr_d     = cap_wr_q;
        enter_resp_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    cap_addr_d  = mem_address[31:2];
                    cap_wdata_d = mem_wdata;
                    cap_be_d    = mem_byte_enable;
                    cap_rd_d    = mem_read;
                    cap_wr_d    = mem_write;
                    if (LATENCY == 1) begin
                        state_d      = S_RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = CNT_LOAD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d      = S_RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Array write word: init data underlies lanes the CPU does not enable.
    always_comb begin
        cpu_idx_s  = eff_addr_s[AW-1:0];
        init_idx_s = init_addr[2 +: AW];
        in_range_s = (eff_addr_s < DEPTH_W);
        init_ok_s  = init_we & (init_addr[31:2] < DEPTH_W);
        cpu_we_s   = enter_resp_s & rst & eff_wr_s & ~eff_rd_s & in_range_s;
        if (init_ok_s && (init_idx_s == cpu_idx_s)) begin
            base_word_s = init_data;
        end else begin
            base_word_s = mem_q[cpu_idx_s];
        end
        cpu_word_s = merge_lanes(base_word_s, eff_wdata_s, eff_be_s);
    end

    // Response flags and read data, all registered on the edge entering RESP.
    always_comb begin
        resp_d  = enter_resp_s;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        if (enter_resp_s) begin
            if (eff_rd_s && eff_wr_s) begin
                err_d = 1'b1;
            end else if (!in_range_s) begin
                err_d = 1'b1;
                if (eff_rd_s) begin
                    rdata_d = 32'h0000_0000;
                end else begin
                    rdata_d = rdata_q;
                end
            end else if (eff_rd_s) begin
                rdata_d = mem_q[cpu_idx_s];
            end else begin
                rdata_d = rdata_q;
            end
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= CNT_ZERO;
            cap_addr_q  <= 30'h0;
            cap_wdata_q <= 32'h0;
            cap_be_q    <= 4'h0;
            cap_rd_q    <= 1'b0;
            cap_wr_q    <= 1'b0;
            rdata_q     <= 32'h0;
            resp_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cap_addr_q  <= cap_addr_d;
            cap_wdata_q <= cap_wdata_d;
            cap_be_q    <= cap_be_d;
            cap_rd_q    <= cap_rd_d;
            cap_wr_q    <= cap_wr_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            err_q       <= err_d;
        end
    end

    // Backing array; contents survive reset, the later CPU write wins on a shared word.
    always_ff @(posedge clk) begin
        if (init_ok_s) begin
            mem_q[init_idx_s] <= init_data;
        end
        if (cpu_we_s) begin
            mem_q[cpu_idx_s] <= cpu_word_s;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_resp  = resp_q;
    assign mem_err   = err_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench: LATENCY=2 instance for directed cases, LATENCY=1 instance for a random sweep.
module tb_cpu_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_rd, a_wr, a_iwe, a_resp, a_err;
    logic [31:0] a_addr, a_wdata, a_iaddr, a_idata, a_rdata;
    logic [3:0]  a_be;

    logic        b_rd, b_wr, b_iwe, b_resp, b_err;
    logic [31:0] b_addr, b_wdata, b_iaddr, b_idata, b_rdata;
    logic [3:0]  b_be;

    cpu_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut_a (
        .clk(clk), .rst(rst), .mem_read(a_rd), .mem_write(a_wr),
        .mem_address(a_addr), .mem_wdata(a_wdata), .mem_byte_enable(a_be),
        .mem_rdata(a_rdata), .mem_resp(a_resp), .mem_err(a_err),
        .init_we(a_iwe), .init_addr(a_iaddr), .init_data(a_idata)
    );

    cpu_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut_b (
        .clk(clk), .rst(rst), .mem_read(b_rd), .mem_write(b_wr),
        .mem_address(b_addr), .mem_wdata(b_wdata), .mem_byte_enable(b_be),
        .mem_rdata(b_rdata), .mem_resp(b_resp), .mem_err(b_err),
        .init_we(b_iwe), .init_addr(b_iaddr), .init_data(b_idata)
    );

    typedef struct {
        int unsigned cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    logic [31:0] ref_b [16];
    logic [31:0] last_b;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor for the LATENCY=2 instance.
    always @(negedge clk) begin
        exp_t e;
        if (!a_resp) begin
            check("a_err_without_resp", {31'b0, a_err}, 32'h0);
        end else begin
            check("a_resp_expected", {31'b0, (qa.size() != 0)}, 32'h1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                check("a_latency", cyc - e.cyc, 32'd2);
                check("a_err", {31'b0, a_err}, {31'b0, e.err});
                check("a_rdata", a_rdata, e.rdata);
            end
        end
    end

    // Monitor for the LATENCY=1 instance.
    always @(negedge clk) begin
        exp_t e;
        if (!b_resp) begin
            check("b_err_without_resp", {31'b0, b_err}, 32'h0);
        end else begin
            check("b_resp_expected", {31'b0, (qb.size() != 0)}, 32'h1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                check("b_latency", cyc - e.cyc, 32'd1);
                check("b_err", {31'b0, b_err}, {31'b0, e.err});
                check("b_rdata", b_rdata, e.rdata);
            end
        end
    end

    task automatic init_a(input logic [31:0] addr, input logic [31:0] data);
        a_iwe = 1'b1; a_iaddr = addr; a_idata = data;
        @(posedge clk); #1;
        a_iwe = 1'b0;
    endtask

    task automatic req_a(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input logic inj, input logic [31:0] iaddr, input logic [31:0] idata);
        int n;
        a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = wdata; a_be = be;
        qa.push_back('{cyc, exp_rdata, exp_err});
        if (inj) begin
            @(posedge clk); #1;
            a_iwe = 1'b1; a_iaddr = iaddr; a_idata = idata;
            @(posedge clk); #1;
            a_iwe = 1'b0;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_resp && n < 12);
        check("a_resp_seen", {31'b0, a_resp}, 32'h1);
        if (!a_resp && qa.size() != 0) void'(qa.pop_back());
        @(posedge clk); #1;
        a_rd = 1'b0; a_wr = 1'b0;
    endtask

    task automatic rd_a(input logic [31:0] addr, input logic [31:0] exp_rdata, input logic exp_err);
        req_a(1'b1, 1'b0, addr, 32'h0, 4'h0, exp_rdata, exp_err, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic wr_a(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                        input logic [31:0] exp_rdata, input logic exp_err);
        req_a(1'b0, 1'b1, addr, data, be, exp_rdata, exp_err, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic req_b(input logic rd, input logic [3:0] w, input logic [31:0] data, input logic [3:0] be);
        int n;
        if (rd) begin
            last_b = ref_b[w];
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) ref_b[w][8*i +: 8] = data[8*i +: 8];
            end
        end
        b_rd = rd; b_wr = ~rd; b_addr = {26'b0, w, 2'b00}; b_wdata = data; b_be = be;
        qb.push_back('{cyc, last_b, 1'b0});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b_resp && n < 12);
        check("b_resp_seen", {31'b0, b_resp}, 32'h1);
        if (!b_resp && qb.size() != 0) void'(qb.pop_back());
        @(posedge clk); #1;
        b_rd = 1'b0; b_wr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  w;
        logic [31:0] d;
        logic [3:0]  be;
        rst = 1'b0;
        a_rd = 1'b0; a_wr = 1'b0; a_addr = 32'h0; a_wdata = 32'h0; a_be = 4'h0;
        a_iwe = 1'b0; a_iaddr = 32'h0; a_idata = 32'h0;
        b_rd = 1'b0; b_wr = 1'b0; b_addr = 32'h0; b_wdata = 32'h0; b_be = 4'h0;
        b_iwe = 1'b0; b_iaddr = 32'h0; b_idata = 32'h0;
        last_b = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp", {31'b0, a_resp}, 32'h0);
        check("rst_err", {31'b0, a_err}, 32'h0);
        check("rst_rdata", a_rdata, 32'h0);
        check("rst_rdata_b", b_rdata, 32'h0);
        rst = 1'b1;

        init_a(32'h0000_000C, 32'hDEAD_BEEF);
        init_a(32'h0000_0014, 32'h1122_3344);
        init_a(32'h0000_0000, 32'hCAFE_F00D);
        init_a(32'h0000_0018, 32'h5555_5555);
        init_a(32'h0000_001C, 32'h0102_0304);

        rd_a(32'h0000_000C, 32'hDEAD_BEEF, 1'b0);
        wr_a(32'h0000_0014, 32'hAABB_CCDD, 4'b0101, 32'hDEAD_BEEF, 1'b0);
        rd_a(32'h0000_0014, 32'h11BB_33DD, 1'b0);
        wr_a(32'h0000_0020, 32'h1234_5678, 4'hF, 32'h11BB_33DD, 1'b0);
        rd_a(32'h0000_0020, 32'h1234_5678, 1'b0);
        rd_a(32'h0000_0400, 32'h0000_0000, 1'b1);
        req_a(1'b1, 1'b1, 32'h0000_0014, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1, 1'b0, 32'h0, 32'h0);
        rd_a(32'h0000_0014, 32'h11BB_33DD, 1'b0);
        wr_a(32'h0000_0014, 32'h0000_0000, 4'b0000, 32'h11BB_33DD, 1'b0);
        rd_a(32'h0000_0014, 32'h11BB_33DD, 1'b0);
        wr_a(32'h0000_0400, 32'h0000_0000, 4'hF, 32'h11BB_33DD, 1'b1);
        rd_a(32'h0000_0000, 32'hCAFE_F00D, 1'b0);
        req_a(1'b0, 1'b1, 32'h0000_0018, 32'hAABB_CCDD, 4'b0011, 32'hCAFE_F00D, 1'b0,
              1'b1, 32'h0000_0018, 32'h1122_3344);
        rd_a(32'h0000_0018, 32'h1122_CCDD, 1'b0);

        a_wr = 1'b1; a_addr = 32'h0000_001C; a_wdata = 32'hFFFF_FFFF; a_be = 4'hF;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("midrst_resp", {31'b0, a_resp}, 32'h0);
        check("midrst_err", {31'b0, a_err}, 32'h0);
        check("midrst_rdata", a_rdata, 32'h0);
        a_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        rd_a(32'h0000_001C, 32'h0102_0304, 1'b0);

        for (int i = 0; i < 16; i++) begin
            ref_b[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
            b_iwe = 1'b1; b_iaddr = 32'(i) << 2; b_idata = ref_b[i];
            @(posedge clk); #1;
        end
        b_iwe = 1'b0;
        for (int i = 0; i < 100; i++) begin
            w  = 4'($urandom_range(0, 15));
            d  = $urandom;
            be = 4'($urandom_range(0, 15));
            req_b(($urandom_range(0, 1) == 1), w, d, be);
        end

        repeat (3) @(posedge clk);
        #1;
        check("a_queue_empty", 32'(qa.size()), 32'h0);
        check("b_queue_empty", 32'(qb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_mem_responder.md
CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words in the backing array; it SHALL be a power of two, at least 4.
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning the number of cycles from request capture to mem_resp; it SHALL be at least 1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port mem_read, input, 1 bit: read request from the CPU controller, held until mem_resp.
REQ-006 The block SHALL have port mem_write, input, 1 bit: write request from the CPU controller, held until mem_resp.
REQ-007 The block SHALL have port mem_address, input, 32 bits: byte address from MAR; bits [1:0] are ignored.
REQ-008 The block SHALL have port mem_wdata, input, 32 bits: write data, already lane-aligned by the CPU.
REQ-009 The block SHALL have port mem_byte_enable, input, 4 bits: write lane enables; bit i enables byte lane [8i+7:8i].
REQ-010 The block SHALL have port mem_rdata, output, 32 bits: read data, valid while mem_resp is high.
REQ-011 The block SHALL have port mem_resp, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port mem_err, output, 1 bit: error flag, valid only while mem_resp is high.
REQ-013 The block SHALL have ports init_we (input, 1 bit), init_addr (input, 32 bits) and init_data (input, 32 bits): a bench preload port that performs a full-word write.

Function
REQ-014 The FSM SHALL have three states.
- IDLE: samples requests.
- BUSY: counts latency.
- RESP: drives the response.
REQ-015 In IDLE, if mem_read or mem_write is high at the clock edge, the block SHALL capture mem_address, mem_wdata, mem_byte_enable and the request type into internal registers.
- LATENCY=1: next state is RESP.
- Otherwise: next state is BUSY, with the counter loaded to LATENCY-2.
REQ-016 In BUSY, the counter SHALL decrement each cycle; at 0 the next state is RESP. Inputs are not re-sampled in BUSY.
REQ-017 mem_resp SHALL be high for exactly the one cycle spent in RESP, which is cycle LATENCY after the first request cycle, cycle 0.
REQ-018 RESP SHALL always go to IDLE on the next edge. Request inputs present during RESP SHALL NOT be captured.
REQ-019 The word index SHALL be captured_address[2 +: log2(DEPTH_WORDS)]. An access is in range only if captured_address[31:2] < DEPTH_WORDS.
REQ-020 On the edge entering RESP, an in-range write SHALL update exactly the byte lanes whose enable is 1. Lanes with enable 0 SHALL retain their old contents.
REQ-021 On the same edge, an in-range read SHALL register the array word into mem_rdata. A read issued after a completed write to the same word SHALL return the written data.
REQ-022 mem_rdata SHALL hold its value until the next read response. Write responses SHALL NOT change mem_rdata.
REQ-023 For an out-of-range access, the block SHALL:
- still produce mem_resp with mem_err=1;
- suppress any write;
- set mem_rdata to 0 for a read.
REQ-024 If mem_read and mem_write are both high at capture, the block SHALL produce mem_resp with mem_err=1, perform no array access, and leave mem_rdata unchanged.
REQ-025 When mem_byte_enable is 4'b0000 on a write, the block SHALL respond normally with mem_err=0 and modify no data.
REQ-026 init_we SHALL write init_data to word init_addr[2 +: log2(DEPTH_WORDS)] on any edge, in any state; an out-of-range init_addr SHALL be ignored.
REQ-027 If an init write and a CPU write target the same word on the same edge, the CPU-enabled lanes SHALL win and the remaining lanes SHALL take init_data.
REQ-028 mem_err SHALL be 0 whenever mem_resp is 0.

Reset
REQ-029 While rst=0, asynchronously, the block SHALL drive: state IDLE, counter 0, mem_resp 0, mem_err 0, mem_rdata 32'h0, and captured registers 0.
REQ-030 Array contents SHALL NOT be reset.
REQ-031 Reset asserted mid-transaction SHALL abort it with no response and no write, unless the RESP edge has already occurred.
REQ-032 After rst deasserts, the first request SHALL be captured on the first rising edge at which it is seen in IDLE.

Verification
REQ-033 Read latency, LATENCY=2: preload word 3 with 32'hDEADBEEF, then hold mem_read with address 32'h0000000C. Required: mem_resp high in cycle 2 only, mem_rdata=32'hDEADBEEF, mem_err=0.
REQ-034 Byte-enable write: with word 5 = 32'h11223344, write 32'hAABBCCDD with enables 4'b0101 to address 32'h14, then read it back. Required: 32'h11BB33DD.
REQ-035 Back-to-back: a write completes, then mem_read is asserted the cycle after RESP. Required: the new request is captured once, only one mem_resp per request, and the read returns the written data.
REQ-036 Errors, DEPTH_WORDS=256: a read at address 32'h00000400 gives mem_resp with mem_err=1 and mem_rdata=0; mem_read and mem_write asserted together give mem_err=1 with the array unchanged.
REQ-037 Reset mid-write: pull rst low during BUSY. Required: outputs go to 0 immediately, no mem_resp is produced, and the target word is unchanged on readback.
REQ-038 LATENCY=1 sweep: 100 random in-range reads and writes checked against a reference model. Required: every mem_resp lands in cycle 1 and all data matches.
